// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: merges N_CH byte producers into one UART transmit stream.
// Each channel owns a small FIFO. A round-robin scan starting after the last
// granted channel picks the next byte, which is held on o_tx_bits until the
// UART pulses i_tx_ready or the watchdog gives up on it.
//
// state  | meaning
// IDLE   | nothing in flight, o_tx_bits = IDLE_BYTE, scanning for a winner
// WAIT   | one byte presented on o_tx_bits, waiting for i_tx_ready
module uart_tx_arbiter #(
  parameter int          N_CH      = 4,
  parameter int          DEPTH     = 4,
  parameter int          TIMEOUT   = 1024,
  parameter logic [7:0]  IDLE_BYTE = 8'h00
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic [N_CH-1:0]         i_ch_valid,
  input  logic [8*N_CH-1:0]       i_ch_data,
  input  logic [N_CH-1:0]         i_ch_enable,
  input  logic                    i_tx_ready,
  input  logic                    i_clear_err,
  output logic [7:0]              o_tx_bits,
  output logic                    o_busy,
  output logic [7:0]              o_last_sent,
  output logic [$clog2(N_CH)-1:0] o_last_ch,
  output logic [N_CH-1:0]         o_overflow,
  output logic                    o_timeout_err
);

  localparam int CW = $clog2(N_CH);
  localparam int AW = $clog2(DEPTH);
  localparam int NW = AW + 1;
  localparam int WW = $clog2(TIMEOUT) + 1;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic [7:0]    r_mem    [N_CH][DEPTH];
  logic [AW-1:0] r_wr_ptr [N_CH];
  logic [AW-1:0] r_rd_ptr [N_CH];
  logic [NW-1:0] r_count  [N_CH];

  logic [CW-1:0] r_rr;
  logic [CW-1:0] r_grant;
  logic [WW-1:0] r_wd;
  logic [7:0]    r_tx_bits;
  logic [7:0]    r_last_sent;
  logic [CW-1:0] r_last_ch;
  logic [N_CH-1:0] r_overflow;
  logic          r_timeout_err;

  logic          w_found;
  logic [CW-1:0] w_win;
  logic          w_take;
  logic          w_done;
  logic          w_expire;
  logic [7:0]    w_head;
  logic [N_CH-1:0] w_push;
  logic [N_CH-1:0] w_pop;
  logic [N_CH-1:0] w_accept;
  logic [N_CH-1:0] w_drop;

  // Round-robin scan: descending loop so the nearest channel after r_rr wins.
  always_comb begin
    logic [CW-1:0] idx;
    idx     = '0;
    w_found = 1'b0;
    w_win   = '0;
    for (int k = N_CH; k >= 1; k--) begin
      idx = CW'((int'(r_rr) + k) % N_CH);
      if ((r_count[idx] != '0) && i_ch_enable[idx]) begin
        w_found = 1'b1;
        w_win   = idx;
      end
    end
  end

  assign w_take   = (r_state == S_IDLE) && w_found;
  assign w_done   = (r_state == S_WAIT) && i_tx_ready;
  assign w_expire = (r_state == S_WAIT) && !i_tx_ready && (r_wd == WW'(TIMEOUT - 1));
  assign w_head   = r_mem[w_win][r_rd_ptr[w_win]];

  // Per-channel push/pop decisions; a full FIFO still accepts when it is popped the same cycle.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      w_push[i]   = i_ch_valid[i] && i_ch_enable[i];
      w_pop[i]    = w_take && (w_win == CW'(i));
      w_accept[i] = w_push[i] && ((r_count[i] != NW'(DEPTH)) || w_pop[i]);
      w_drop[i]   = w_push[i] && !w_accept[i];
    end
  end

  // FIFO storage; contents need no reset because count/pointers gate every read.
  always_ff @(posedge i_clock) begin
    for (int i = 0; i < N_CH; i++) begin
      if (w_accept[i]) begin
        r_mem[i][r_wr_ptr[i]] <= i_ch_data[8*i +: 8];
      end
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < N_CH; i++) begin
        r_wr_ptr[i] <= '0;
        r_rd_ptr[i] <= '0;
        r_count[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (w_accept[i]) r_wr_ptr[i] <= r_wr_ptr[i] + 1'b1;
        if (w_pop[i])    r_rd_ptr[i] <= r_rd_ptr[i] + 1'b1;
        r_count[i] <= r_count[i] + NW'(w_accept[i]) - NW'(w_pop[i]);
      end
    end
  end

  // State register.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state logic: grant from IDLE, leave WAIT on completion or watchdog expiry.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_take) w_state_nxt = S_WAIT;
      S_WAIT:  if (w_done || w_expire) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode from state.
  always_comb begin
    o_busy = (r_state == S_WAIT);
  end

  // Datapath: presented byte, rr pointer, watchdog, completion record, sticky flags (set beats clear).
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_tx_bits     <= IDLE_BYTE;
      r_rr          <= '0;
      r_grant       <= '0;
      r_wd          <= '0;
      r_last_sent   <= 8'h00;
      r_last_ch     <= '0;
      r_overflow    <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (w_take) begin
        r_tx_bits <= w_head;
        r_grant   <= w_win;
        r_rr      <= w_win;
        r_wd      <= '0;
      end else if (w_done || w_expire) begin
        r_tx_bits <= IDLE_BYTE;
        if (w_done) begin
          r_last_sent <= r_tx_bits;
          r_last_ch   <= r_grant;
        end
      end else if (r_state == S_WAIT) begin
        r_wd <= r_wd + 1'b1;
      end
      r_overflow    <= (i_clear_err ? '0 : r_overflow) | w_drop;
      r_timeout_err <= (i_clear_err ? 1'b0 : r_timeout_err) | w_expire;
    end
  end

  assign o_tx_bits     = r_tx_bits;
  assign o_last_sent   = r_last_sent;
  assign o_last_ch     = r_last_ch;
  assign o_overflow    = r_overflow;
  assign o_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: a queue-based reference model predicts
// grant/complete/timeout events; a negedge monitor pops and compares them.
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int D  = 4;
  localparam int TO = 1024;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   valid = '0;
  logic [8*N-1:0] data = '0;
  logic [N-1:0]   en = '1;
  logic           rdy = 1'b0;
  logic           clr = 1'b0;
  logic [7:0]     o_tx_bits;
  logic           o_busy;
  logic [7:0]     o_last_sent;
  logic [1:0]     o_last_ch;
  logic [N-1:0]   o_overflow;
  logic           o_timeout_err;

  uart_tx_arbiter #(.N_CH(N), .DEPTH(D), .TIMEOUT(TO), .IDLE_BYTE(8'h00)) dut (
    .i_clock(clk), .i_reset(rst), .i_ch_valid(valid), .i_ch_data(data),
    .i_ch_enable(en), .i_tx_ready(rdy), .i_clear_err(clr),
    .o_tx_bits(o_tx_bits), .o_busy(o_busy), .o_last_sent(o_last_sent),
    .o_last_ch(o_last_ch), .o_overflow(o_overflow), .o_timeout_err(o_timeout_err));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: queues per channel, one in-flight slot, deadline-based watchdog.
  typedef struct { int kind; logic [7:0] data; int ch; int cyc; } ev_t;  // kind 0=grant 1=done 2=timeout
  ev_t        exp_q[$];
  logic [7:0] mq [N][$];
  bit         m_busy;
  logic [7:0] m_byte;
  int         m_ch, m_rr, m_deadline, m_last_ch, cyc = 0;
  logic [7:0] m_last;
  logic [N-1:0] m_ovf;
  bit         m_terr;

  always @(posedge clk or posedge rst) begin
    int pop_ch, c;
    logic [N-1:0] new_ovf;
    bit new_terr;
    ev_t ev;
    if (rst) begin
      for (int i = 0; i < N; i++) mq[i].delete();
      exp_q.delete();
      m_busy = 0; m_byte = 0; m_ch = 0; m_rr = 0; m_deadline = 0;
      m_last = 0; m_last_ch = 0; m_ovf = '0; m_terr = 0;
    end else begin
      cyc++;
      new_ovf  = clr ? '0 : m_ovf;
      new_terr = clr ? 1'b0 : m_terr;
      if (!m_busy) begin
        pop_ch = -1;
        for (int k = 1; k <= N; k++) begin
          c = (m_rr + k) % N;
          if (pop_ch < 0 && mq[c].size() > 0 && en[c]) pop_ch = c;
        end
        if (pop_ch >= 0) begin
          m_byte = mq[pop_ch].pop_front();
          m_ch = pop_ch; m_rr = pop_ch; m_busy = 1; m_deadline = cyc + TO;
          ev.kind = 0; ev.data = m_byte; ev.ch = m_ch; ev.cyc = cyc; exp_q.push_back(ev);
        end
      end else if (rdy) begin
        m_busy = 0; m_last = m_byte; m_last_ch = m_ch;
        ev.kind = 1; ev.data = m_last; ev.ch = m_last_ch; ev.cyc = cyc; exp_q.push_back(ev);
      end else if (cyc == m_deadline) begin
        m_busy = 0; new_terr = 1;
        ev.kind = 2; ev.data = m_last; ev.ch = m_last_ch; ev.cyc = cyc; exp_q.push_back(ev);
      end
      for (int i = 0; i < N; i++) begin
        if (valid[i] && en[i]) begin
          if (mq[i].size() < D) mq[i].push_back(data[8*i +: 8]);
          else new_ovf[i] = 1'b1;
        end
      end
      m_ovf = new_ovf; m_terr = new_terr;
    end
  end

  // Monitor: compares flags every cycle and pops an expected event on each busy transition.
  bit prev_busy = 0;
  always @(negedge clk) begin
    ev_t ev;
    if (rst) begin
      prev_busy = 0;
    end else begin
      chk("busy", o_busy, m_busy);
      chk("overflow", o_overflow, m_ovf);
      chk("timeout_err", o_timeout_err, m_terr);
      if (o_busy != prev_busy) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_event", o_busy, prev_busy);
        end else begin
          ev = exp_q.pop_front();
          chk("event_cycle", cyc, ev.cyc);
          if (o_busy) begin
            chk("event_is_grant", ev.kind == 0, 1);
            chk("grant_tx_bits", o_tx_bits, ev.data);
          end else begin
            chk("event_is_end", ev.kind != 0, 1);
            chk("idle_tx_bits", o_tx_bits, 8'h00);
            chk("last_sent", o_last_sent, ev.data);
            chk("last_ch", o_last_ch, ev.ch);
          end
        end
      end else if (o_busy && m_busy) begin
        chk("tx_bits_hold", o_tx_bits, m_byte);
      end
      prev_busy = o_busy;
    end
  end

  int rdy_mode = 0;  // 0 never, 1 random when busy, 2 random always, 3 immediately when busy

  task automatic step();
    case (rdy_mode)
      1:       rdy = o_busy && ($urandom % 4 == 0);
      2:       rdy = ($urandom % 3 == 0);
      3:       rdy = o_busy;
      default: rdy = 1'b0;
    endcase
    @(negedge clk);
    valid = '0; rdy = 1'b0; clr = 1'b0;
  endtask

  task automatic push1(int ch, logic [7:0] b);
    valid[ch] = 1'b1;
    data[8*ch +: 8] = b;
    step();
  endtask

  function automatic bit drained();
    bit d;
    d = !m_busy;
    for (int i = 0; i < N; i++) if (en[i] && mq[i].size() != 0) d = 0;
    return d;
  endfunction

  task automatic drain(int budget);
    int n;
    n = 0;
    while (!drained() && n < budget) begin step(); n++; end
    chk("drain_in_budget", drained(), 1);
    step();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_tx_bits", o_tx_bits, 8'h00);
    chk("rst_busy", o_busy, 0);
    chk("rst_last_sent", o_last_sent, 8'h00);
    chk("rst_last_ch", o_last_ch, 0);
    chk("rst_overflow", o_overflow, 0);
    chk("rst_timeout_err", o_timeout_err, 0);

    // Single byte latency and completion.
    rdy_mode = 0;
    push1(0, 8'hA5);
    step();
    chk("t1_busy", o_busy, 1);
    chk("t1_tx_bits", o_tx_bits, 8'hA5);
    rdy_mode = 3;
    step();
    chk("t1_last_sent", o_last_sent, 8'hA5);
    chk("t1_last_ch", o_last_ch, 0);
    chk("t1_busy_low", o_busy, 0);
    chk("t1_tx_idle", o_tx_bits, 8'h00);

    // Same-cycle pushes on ch0..ch2, rr=0: order ch1, ch2, ch0.
    rdy_mode = 0;
    valid = 4'b0111; data = {8'h00, 8'h30, 8'h20, 8'h10};
    step();
    step();
    chk("t2_first", o_tx_bits, 8'h20);
    rdy_mode = 3;
    drain(50);
    chk("t2_last_sent", o_last_sent, 8'h10);
    chk("t2_last_ch", o_last_ch, 0);

    // Overflow on ch3 while ch0 blocks the UART.
    rdy_mode = 0;
    push1(0, 8'h11);
    for (int j = 0; j < 5; j++) push1(3, 8'h30 + 8'(j));
    chk("t3_overflow", o_overflow, 4'b1000);
    rdy_mode = 1;
    drain(400);
    chk("t3_last_sent", o_last_sent, 8'h33);
    clr = 1'b1;
    step();
    chk("t3_overflow_clr", o_overflow, 0);

    // Watchdog expiry, then the next queued byte is granted.
    rdy_mode = 0;
    push1(1, 8'h41);
    push1(2, 8'h42);
    repeat (TO + 5) step();
    chk("t4_timeout_err", o_timeout_err, 1);
    chk("t4_last_sent_kept", o_last_sent, 8'h33);
    chk("t4_next_busy", o_busy, 1);
    chk("t4_next_byte", o_tx_bits, 8'h42);
    rdy_mode = 1;
    drain(400);
    clr = 1'b1;
    step();
    chk("t4_timeout_clr", o_timeout_err, 0);

    // Disabled channel retains its queue; pushes while disabled vanish.
    rdy_mode = 0;
    push1(0, 8'h51);
    push1(1, 8'h61);
    push1(1, 8'h62);
    en[1] = 1'b0;
    push1(2, 8'h71);
    push1(1, 8'h6F);
    rdy_mode = 1;
    drain(400);
    repeat (10) step();
    chk("t5_blocked_idle", o_busy, 0);
    chk("t5_last_sent", o_last_sent, 8'h71);
    en[1] = 1'b1;
    drain(400);
    chk("t5_reenabled_last", o_last_sent, 8'h62);
    chk("t5_reenabled_ch", o_last_ch, 1);

    // Reset in the middle of WAIT with full FIFOs.
    rdy_mode = 0;
    repeat (6) begin
      valid = '1; data = $urandom;
      step();
    end
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_busy", o_busy, 0);
    chk("t6_rst_tx_bits", o_tx_bits, 8'h00);
    chk("t6_rst_last_sent", o_last_sent, 8'h00);
    chk("t6_rst_last_ch", o_last_ch, 0);
    chk("t6_rst_overflow", o_overflow, 0);
    chk("t6_rst_timeout", o_timeout_err, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    rdy_mode = 2;
    repeat (30) step();
    chk("t6_no_send", o_busy, 0);
    chk("t6_no_last", o_last_sent, 8'h00);

    // Randomized traffic.
    rdy_mode = 2;
    for (int c = 0; c < 3000; c++) begin
      valid = N'($urandom);
      data  = $urandom;
      en    = ~N'($urandom & $urandom & $urandom);
      clr   = ($urandom % 50 == 0);
      step();
    end
    en = '1;
    rdy_mode = 1;
    drain(2000);
    chk("exp_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_time_limit: got expired expected finish");
    $fatal(1, "time limit");
  end
endmodule
